// File: rtl/sram_access_ctrl_pkg.sv
// sram_pkg: analog levels, controller FSM states and logic-to-level conversion
// shared by the SRAM access controller files.
package sram_pkg;
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;
    typedef enum logic [2:0] {IDLE, PRECHARGE, WL_READ, SENSE, WRITE, RESP} state_t;
    function automatic real lvl(input logic b);
        return b ? VDD : VSS;
    endfunction
endpackage

// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: host request/response handshake of the SRAM access controller.
interface sram_access_ctrl_if #(
    parameter int ROWS = 16,
    parameter int COLS = 8
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic [COLS-1:0] rsp_rdata;
    logic            rsp_err;
    modport master (output req_valid, req_we, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/sram_access_ctrl_wl_driver.sv
// sram_wl_driver: one-hot decode of (addr, enable) into real-valued wordlines;
// an address with no matching row leaves every line at VSS.
module sram_wl_driver
    import sram_pkg::*;
#(
    parameter int ROWS = 16,
    parameter int AW   = 4
) (
    input  logic          i_addr_en,
    input  logic [AW-1:0] i_addr,
    output real           o_wl [ROWS]
);
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign o_wl[r] = lvl(i_addr_en && 32'(i_addr) == r);
    end
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences precharge, wordline, sense and write windows of the SRAM array.
// Build option SRAM_ACCESS_CTRL_WR_VERIFY_EN adds a read-back verify after every write.
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int PRE_CYC = 2,
    parameter int WL_CYC  = 2,
    parameter int WR_CYC  = 3
) (
    input  logic clk,
    input  logic rst,
    sram_access_ctrl_if.slave bus,
    output logic pre_en,
    output logic sa_en,
    output real  row_rd [ROWS],
    output real  row_wr [ROWS],
    output real  bl_wr  [COLS],
    output real  blb_wr [COLS],
    input  real  preout [COLS]
);
    localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = 8;
    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [COLS-1:0] r_wdata, r_rdata, w_sense, w_word;
    logic            w_accept, w_vfy, w_oor, w_rd_en, w_wr_en, w_bl_en;
    assign w_accept = bus.req_valid && bus.req_ready;
    assign w_oor    = 32'(r_addr) >= ROWS;
    assign w_word   = w_oor ? '0 : w_sense;
    for (genvar c = 0; c < COLS; c++) begin : g_col
        assign w_sense[c] = preout[c] >= VTH;
        assign bl_wr[c]   = lvl(w_bl_en && r_wdata[c]);
        assign blb_wr[c]  = lvl(w_bl_en && !r_wdata[c]);
    end
`ifdef SRAM_ACCESS_CTRL_WR_VERIFY_EN
    logic r_vfy, r_err;
    assign w_vfy   = r_vfy;
    assign w_bl_en = r_state == WRITE;
    assign bus.rsp_err = r_state == RESP && r_err;
    // r_vfy marks the read-back pass that follows the write drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vfy <= 1'b0;
            r_err <= 1'b0;
        end else begin
            if (w_accept)
                r_vfy <= 1'b0;
            else if (r_state == WRITE && w_next == PRECHARGE)
                r_vfy <= 1'b1;
            if (w_accept)
                r_err <= 1'b0;
            else if (r_state == SENSE)
                r_err <= r_vfy && w_word != r_wdata;
        end
    end
`else
    assign w_vfy   = 1'b0;
    assign w_bl_en = r_state == WRITE || (r_state == RESP && r_we);
    assign bus.rsp_err = 1'b0;
`endif
    assign bus.req_ready = r_state == IDLE;
    assign bus.rsp_valid = r_state == RESP;
    assign bus.rsp_rdata = r_rdata;
    assign pre_en  = r_state == PRECHARGE;
    assign sa_en   = r_state == SENSE;
    assign w_rd_en = r_state == WL_READ || r_state == SENSE;
    assign w_wr_en = r_state == WRITE;
    sram_wl_driver #(.ROWS(ROWS), .AW(AW)) u_rd_wl (
        .i_addr_en (w_rd_en),
        .i_addr    (r_addr),
        .o_wl      (row_rd)
    );
    sram_wl_driver #(.ROWS(ROWS), .AW(AW)) u_wr_wl (
        .i_addr_en (w_wr_en),
        .i_addr    (r_addr),
        .o_wl      (row_wr)
    );
    always_comb begin
        w_next = r_state;
        w_cnt  = (r_cnt != '0) ? r_cnt - CW'(1) : r_cnt;
        case (r_state)
            IDLE: if (bus.req_valid) begin
                w_next = PRECHARGE;
                w_cnt  = CW'(PRE_CYC - 1);
            end
            PRECHARGE: if (r_cnt == '0) begin
                w_next = (r_we && !w_vfy) ? WRITE : WL_READ;
                w_cnt  = CW'((r_we && !w_vfy) ? WR_CYC - 1 : WL_CYC - 1);
            end
            WL_READ: if (r_cnt == '0) w_next = SENSE;
            SENSE:   w_next = RESP;
`ifdef SRAM_ACCESS_CTRL_WR_VERIFY_EN
            WRITE: if (r_cnt == '0) begin
                w_next = PRECHARGE;
                w_cnt  = CW'(PRE_CYC - 1);
            end
`else
            WRITE: if (r_cnt == '0) w_next = RESP;
`endif
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == SENSE)
                r_rdata <= w_word;
        end
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: scoreboard bench with a behavioural array / sense-amp model.
module tb_sram_access_ctrl;
    import sram_pkg::*;
    localparam int ROWS = 16;
    localparam int COLS = 8;
`ifdef SRAM_ACCESS_CTRL_WR_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif
    localparam int WLAT = VFY ? 11 : 6;
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pre_en, sa_en;
    real  row_rd [ROWS];
    real  row_wr [ROWS];
    real  bl_wr  [COLS];
    real  blb_wr [COLS];
    real  preout [COLS];
    real  ovr_val [COLS];
    logic ovr = 1'b0;
    logic [7:0] stuck0 = 8'h00;
    logic [7:0] mem [ROWS] = '{default: 8'h00};
    logic [7:0] bl_cap, blb_cap, bl_resp, last_rd;
    exp_t sbq [$];
    int   n_tests = 0, n_fail = 0, cyc = 0, pre_cnt = 0;
    int   rd_cnt [ROWS];
    int   wr_cnt [ROWS];
    logic inv_bad = 1'b0;
    sram_access_ctrl_if #(.ROWS(ROWS), .COLS(COLS)) bus ();
    sram_access_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .pre_en (pre_en),
        .sa_en  (sa_en),
        .row_rd (row_rd),
        .row_wr (row_wr),
        .bl_wr  (bl_wr),
        .blb_wr (blb_wr),
        .preout (preout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic hi(input real v);
        return v == VDD;
    endfunction
    function automatic int sum_mv();
        int s = 0;
        for (int r = 0; r < ROWS; r++) s += int'(row_rd[r] * 1000.0) + int'(row_wr[r] * 1000.0);
        for (int c = 0; c < COLS; c++) s += int'(bl_wr[c] * 1000.0) + int'(blb_wr[c] * 1000.0);
        return s;
    endfunction
    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    // array: a raised write wordline stores the bitline pattern; sense-amps see the raised read row
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            preout[c] = VSS;
            for (int r = 0; r < ROWS; r++)
                if (hi(row_rd[r]) && mem[r][c] && !stuck0[c]) preout[c] = VDD;
            if (ovr) preout[c] = ovr_val[c];
        end
    end
    always @(posedge clk)
        for (int r = 0; r < ROWS; r++)
            if (hi(row_wr[r]))
                for (int c = 0; c < COLS; c++) mem[r][c] <= hi(bl_wr[c]);
    always @(negedge clk) begin
        int nh;
        nh = 0;
        for (int r = 0; r < ROWS; r++) begin
            if (hi(row_rd[r])) begin nh++; rd_cnt[r]++; end
            if (hi(row_wr[r])) begin
                nh++;
                wr_cnt[r]++;
                for (int c = 0; c < COLS; c++) begin
                    bl_cap[c]  = hi(bl_wr[c]);
                    blb_cap[c] = hi(blb_wr[c]);
                end
            end
        end
        if (nh > 1 || (pre_en && nh > 0)) inv_bad = 1'b1;
        if (pre_en) pre_cnt++;
        if (bus.rsp_valid) begin
            for (int c = 0; c < COLS; c++) bl_resp[c] = hi(bl_wr[c]);
            if (sbq.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("rdata", bus.rsp_rdata, e.rdata);
                chk("err", bus.rsp_err, e.err);
                chk("latency", cyc - e.acc, e.lat);
            end
        end
    end
    task automatic clr();
        pre_cnt = 0;
        for (int r = 0; r < ROWS; r++) begin rd_cnt[r] = 0; wr_cnt[r] = 0; end
    endtask
    task automatic req(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                       input logic [7:0] er, input logic ee, input int lat, output int acc);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        do begin @(posedge clk); n++; end while (!bus.req_ready && n < 50);
        acc = cyc;
        if (!bus.req_ready) chk("accept_timeout", 0, 1);
        else sbq.push_back('{er, ee, lat, cyc});
        #1 bus.req_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain_timeout", sbq.size(), 0);
        @(negedge clk);
    endtask
    initial begin
        int a0, a1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        last_rd = 8'h00;
        clr();
        repeat (3) @(negedge clk);
        chk("rst_pre_en", pre_en, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);
        chk("rst_drives", sum_mv(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", bus.req_ready, 1);
        clr();
        req(1'b1, 4'd5, 8'hA5, VFY ? 8'hA5 : last_rd, 1'b0, WLAT, a0);
        if (VFY) last_rd = 8'hA5;
        drain();
        chk("wr_row5_cycles", wr_cnt[5], 3);
        chk("wr_bl", bl_cap, 8'hA5);
        chk("wr_blb", blb_cap, 8'h5A);
        chk("wr_bl_in_resp", bl_resp, VFY ? 8'h00 : 8'hA5);
        chk("wr_pre_cycles", pre_cnt, VFY ? 4 : 2);
        chk("idle_drives", sum_mv(), 0);
        clr();
        req(1'b0, 4'd5, 8'h00, 8'hA5, 1'b0, 6, a0);
        last_rd = 8'hA5;
        drain();
        chk("rd_pre_cycles", pre_cnt, 2);
        chk("rd_row5_cycles", rd_cnt[5], 3);
        ovr_val = '{0.79, 1.5, 0.0, 0.8, 0.0, 1.5, 0.79, 0.8};
        ovr = 1'b1;
        req(1'b0, 4'd3, 8'h00, 8'hAA, 1'b0, 6, a0);
        drain();
        ovr = 1'b0;
        last_rd = 8'hAA;
        req(1'b1, 4'd0, 8'h3C, VFY ? 8'h3C : last_rd, 1'b0, WLAT, a0);
        if (VFY) last_rd = 8'h3C;
        drain();
        req(1'b1, 4'd15, 8'hC3, VFY ? 8'hC3 : last_rd, 1'b0, WLAT, a0);
        drain();
        clr();
        req(1'b0, 4'd0, 8'h00, 8'h3C, 1'b0, 6, a0);
        req(1'b0, 4'd15, 8'h00, 8'hC3, 1'b0, 6, a1);
        last_rd = 8'hC3;
        drain();
        chk("b2b_gap", a1 - a0, 7);
        chk("b2b_row0", rd_cnt[0], 3);
        chk("b2b_row15", rd_cnt[15], 3);
        stuck0 = 8'h08;
        req(1'b1, 4'd7, 8'hFF, VFY ? 8'hF7 : last_rd, VFY, WLAT, a0);
        if (VFY) last_rd = 8'hF7;
        drain();
        stuck0 = 8'h00;
        req(1'b1, 4'd8, 8'hFF, VFY ? 8'hFF : last_rd, 1'b0, WLAT, a0);
        if (VFY) last_rd = 8'hFF;
        drain();
        req(1'b1, 4'd2, 8'h5A, 8'h00, 1'b0, 0, a0);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_wr_row2", int'(row_wr[2] * 1000.0), 1500);
        rst = 1'b1;
        #1;
        chk("mid_wr_drives", sum_mv(), 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_wr_ready", bus.req_ready, 1);
        chk("mid_wr_rdata", bus.rsp_rdata, 0);
        repeat (12) @(negedge clk);
        chk("invariant", inv_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Sequences single-port read and write accesses to the mixed-signal SRAM array and its column sense amplifiers.
- Accepts one request at a time over a valid/ready handshake.
- Drives real-valued read/write wordlines and bitline write drivers, times precharge, wordline and sense windows, then thresholds the sense-amp `preout` lines into a registered read word.
- Sits between the digital host interface and the analog array plus sense-amp macro.

Parameters:
- ROWS, 16, number of wordlines; address width AW = $clog2(ROWS).
- COLS, 8, data word width (one bit per column).
- PRE_CYC, 2, precharge duration in clocks (>=1).
- WL_CYC, 2, read wordline-on duration before sensing, in clocks (>=1).
- WR_CYC, 3, write wordline plus bitline drive duration in clocks (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request (high only in IDLE).
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  AW  row address.
- req_wdata  in  COLS  write data.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  COLS  read data; holds its value until the next read completes.
- rsp_err  out  1  write-verify mismatch; tied 0 without the optional feature.
- pre_en  out  1  bitline precharge enable.
- sa_en  out  1  sense-amp sample strobe.
- row_rd  out  real[ROWS]  read wordlines, VDD or VSS.
- row_wr  out  real[ROWS]  write wordlines, VDD or VSS.
- bl_wr  out  real[COLS]  write bitline drive.
- blb_wr  out  real[COLS]  complementary write bitline drive.
- preout  in  real[COLS]  sense-amp outputs.

Behaviour:
- Reset (async, immediate):
  - All row_rd, row_wr, bl_wr and blb_wr outputs = VSS (0.0).
  - pre_en = sa_en = rsp_valid = rsp_err = 0; rsp_rdata = 0.
  - FSM = IDLE; req_ready = 1 after reset is released.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. On acceptance, addr, we and wdata are latched into internal registers. Inputs are ignored when req_ready = 0.
- FSM states: IDLE, PRECHARGE, WL_READ, SENSE, WRITE, RESP. A single down-counter times each state.
- IDLE -> PRECHARGE on accept, with the counter loaded to PRE_CYC-1. pre_en = 1 for PRE_CYC cycles.
- PRECHARGE -> WL_READ if read, or WRITE if write. pre_en drops in the same cycle.
- WL_READ:
  - row_rd[addr] = VDD; all other rows = VSS.
  - Lasts WL_CYC cycles, then -> SENSE.
- SENSE:
  - Lasts 1 cycle; row_rd[addr] stays VDD and sa_en = 1.
  - At the end of the cycle, rsp_rdata[c] <= (preout[c] >= VTH), with VTH = 0.8.
  - Then -> RESP.
- WRITE:
  - row_wr[addr] = VDD.
  - For each column c: bl_wr[c] = VDD and blb_wr[c] = VSS when wdata[c] = 1; reversed when wdata[c] = 0.
  - Lasts WR_CYC cycles.
  - Leaving WRITE: row_wr returns to VSS first; bl_wr and blb_wr return to VSS in the following RESP cycle.
  - Then -> RESP.
- RESP: rsp_valid = 1 for exactly one cycle, then -> IDLE.
- Latency (accept edge to rsp_valid high):
  - Read: PRE_CYC + WL_CYC + 2 cycles (defaults: 6).
  - Write: PRE_CYC + WR_CYC + 1 cycles (defaults: 6).
  - Back-to-back: req_ready returns the cycle after RESP, so a new request is accepted at the earliest one cycle after rsp_valid.
- Invariant: at most one row_rd or row_wr line is at VDD at any time, and never a row_rd and row_wr line simultaneously. pre_en and any wordline are never high together.
- Out-of-range address (addr >= ROWS when ROWS is not a power of 2): the request is accepted, no wordline is driven, rsp_rdata = 0, and the response is still issued.
- A preout value exactly equal to 0.8 reads as 1.
- Reset mid-access: all drives go to VSS immediately and the in-flight request is dropped with no rsp_valid.

Optional Feature:
- Macro: SRAM_ACCESS_CTRL_WR_VERIFY_EN.
- Enabled: after WRITE, the FSM executes PRECHARGE -> WL_READ -> SENSE on the same row before RESP.
  - rsp_err = 1 in the RESP cycle if the sensed word != wdata, otherwise 0.
  - rsp_rdata is updated with the sensed word.
  - Write latency becomes PRE_CYC + WR_CYC + PRE_CYC + WL_CYC + 2 (defaults: 11).
- Disabled: rsp_err is tied 0 and no verify states are compiled.

Decomposition:
- Package sram_pkg holds:
  - constants VDD = 1.5, VSS = 0.0, VTH = 0.8;
  - the FSM state enum;
  - a function for logic-to-real level conversion.
- Sub-module sram_wl_driver: one-hot decode of (addr, enable) to a real[ROWS] wordline vector. Instantiated twice, for the read and write wordlines.

Test Plan:
- Reset mid-WRITE (asserted in WRITE cycle 2):
  - all wordlines and bitlines read 0.0 in the same timestep;
  - no rsp_valid follows;
  - req_ready = 1 after release.
- Write addr=5, wdata=8'hA5, defaults:
  - row_wr[5] = 1.5 for 3 cycles;
  - bl_wr = {1.5, 0, 1.5, 0, 0, 1.5, 0, 1.5} (bit 7 down to bit 0);
  - rsp_valid exactly 6 cycles after accept.
- Read addr=5, with the array model returning preout = 1.5 on bits 7, 5, 2, 0 and 0.0 elsewhere:
  - pre_en high for 2 cycles;
  - row_rd[5] high for 3 cycles;
  - rsp_rdata = 8'hA5 at rsp_valid, 6 cycles after accept.
- Threshold: preout = {0.8, 0.79, ...}:
  - bit 7 reads 1, bit 6 reads 0.
- Back-to-back: req_valid held high with read addr 0 then read addr 15:
  - second accept occurs 1 cycle after the first rsp_valid;
  - req_ready low throughout each access;
  - single-wordline invariant holds (assertion).
- With SRAM_ACCESS_CTRL_WR_VERIFY_EN defined, array model stuck-at-0 on column 3, write 8'hFF:
  - rsp_err = 1 and rsp_rdata = 8'hF7 after 11 cycles;
  - repeat with a healthy array: rsp_err = 0.
